// File: rtl/button_counter.sv
// rtl/button_counter.sv - debounced push-button up/down event counter
//
// Purpose: samples a bouncing active-low push button and an up/down switch,
// debounces the button with a clock-based timer and steps a binary count once
// per clean press. The count drives active-low LEDs.
//
// Ports:
//   clk    in   system clock, single domain
//   rst    in   synchronous active-high reset
//   btn_n  in   raw push button, active-low, asynchronous
//   up     in   raw direction switch, asynchronous (1 = up, 0 = down)
//   q      out  WIDTH-bit count for LEDs, active-low (~count)
//   press  out  one-cycle pulse on each accepted press, aligned with q update
//   held   out  high while the debounced button is considered pressed
`timescale 1ns/1ps

module button_counter #(
  parameter int CLK_FREQ    = 12000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int WIDTH       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_n,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             press,
  output logic             held
);

  // Debounce interval in clock cycles; must be at least 2.
  localparam int N  = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic             btn_m;
  logic             btn_s;
  logic             up_m;
  logic             up_s;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      up_m  <= 1'b0;
      up_s  <= 1'b0;
      state <= RELEASED;
      cnt   <= '0;
      count <= '0;
      press <= 1'b0;
      held  <= 1'b0;
    end else begin
      // Two-flop synchronizers; the button is inverted so 1 means pressed.
      btn_m <= ~btn_n;
      btn_s <= btn_m;
      up_m  <= up;
      up_s  <= up_m;

      press <= 1'b0;

      case (state)
        RELEASED: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!btn_s) begin
            // Contact bounce before the interval elapsed: no press.
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            press <= 1'b1;
            held  <= 1'b1;
            // Direction is only looked at here, once per press.
            count <= up_s ? count + WIDTH'(1) : count - WIDTH'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        PRESSED: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (btn_s) begin
            // Release bounce: still the same press, no new pulse.
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= RELEASED;
            cnt   <= '0;
            held  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= RELEASED;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

  assign q = ~count;

endmodule
